// File: rtl/fetch_writeback.sv
// Fetch/decode/write-back front end for the single-issue core: owns the PC, the
// 32x32 register file and the instruction ROM port, sequenced by a 4-state FSM.
module fetch_writeback #(
  parameter int          IADDR_W  = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  output logic [31:0]        reg1,
  output logic [31:0]        reg2,
  input  logic [4:0]         wra,
  input  logic [31:0]        result,
  input  logic [31:0]        nextpc,
  output logic               retire,
  output logic [31:0]        icount,
  input  logic [4:0]         dbg_addr,
  output logic [31:0]        dbg_data
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] rf [32];
  logic [4:0]  rs, rt;

  assign rs        = ins[25:21];
  assign rt        = ins[20:16];
  assign imem_addr = pc[IADDR_W-1:0];

  // r0 is never written, but the explicit zero keeps reads independent of rf[0].
  assign reg1     = (rs == 5'd0)       ? 32'd0 : rf[rs];
  assign reg2     = (rt == 5'd0)       ? 32'd0 : rf[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      FETCH:  if (run) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = WB;
      WB: begin
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ins    <= '0;
      icount <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      // ROM data for pc arrives one cycle after FETCH, i.e. during DECODE.
      if (state == DECODE) ins <= imem_rdata;
      if (state == WB) begin
        pc     <= nextpc;
        icount <= icount + 32'd1;
        if (wra != 5'd0) rf[wra] <= result;
      end
    end
  end

endmodule

// File: tb/tb_fetch_writeback.sv
// Directed bench for fetch_writeback: table of instructions with hand-computed
// operand/write-back expectations, plus stall and reset-mid-instruction sequences.
module tb_fetch_writeback;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ins, pc, reg1, reg2, result, nextpc, icount, dbg_data;
  logic [4:0]  wra, dbg_addr;
  logic        retire;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [256];

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  fetch_writeback #(.IADDR_W(8), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins(ins), .pc(pc), .reg1(reg1), .reg2(reg2),
    .wra(wra), .result(result), .nextpc(nextpc),
    .retire(retire), .icount(icount),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] exp_reg1;
    logic [31:0] exp_reg2;
    logic [4:0]  wra;
    logic [31:0] result;
    logic [31:0] nextpc;
  } vec_t;

  vec_t vec [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one instruction from FETCH (called at a negedge in FETCH); run is
  // dropped in DECODE so the FSM parks in FETCH afterwards.
  task automatic run_instr(input vec_t v, input logic [31:0] spc, input int icnt);
    logic [31:0] exp_dbg;
    exp_dbg  = (v.wra == 5'd0) ? 32'd0 : v.result;
    dbg_addr = v.wra;
    wra      = v.wra;
    result   = v.result;
    nextpc   = v.nextpc;
    run      = 1'b1;
    check("imem_addr_fetch", {24'd0, imem_addr}, {24'd0, spc[7:0]});
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("ins_exec", ins, v.ins);
    check("reg1_exec", reg1, v.exp_reg1);
    check("reg2_exec", reg2, v.exp_reg2);
    check("retire_exec", {31'd0, retire}, 32'd0);
    check("pc_exec", pc, spc);
    @(negedge clk);
    check("retire_wb", {31'd0, retire}, 32'd1);
    check("reg1_wb", reg1, v.exp_reg1);
    check("pc_wb", pc, spc);
    @(negedge clk);
    check("retire_after", {31'd0, retire}, 32'd0);
    check("pc_after", pc, v.nextpc);
    check("imem_addr_after", {24'd0, imem_addr}, {24'd0, v.nextpc[7:0]});
    check("dbg_after", dbg_data, exp_dbg);
    check("icount_after", icount, icnt);
  endtask

  task automatic check_reset_state();
    check("rst_pc", pc, 32'd0);
    check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_icount", icount, 32'd0);
    check("rst_reg1", reg1, 32'd0);
    check("rst_reg2", reg2, 32'd0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      check("rst_dbg", dbg_data, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] spc;
    logic [31:0] hold_pc, hold_ic;

    //          ins           reg1          reg2          wra    result        nextpc
    vec[0] = '{32'h04010005, 32'h0,        32'h0,        5'd1,  32'h5,        32'h1};
    vec[1] = '{32'h00221800, 32'h5,        32'h0,        5'd2,  32'h12345678, 32'h2};
    vec[2] = '{32'h00410000, 32'h12345678, 32'h5,        5'd0,  32'hDEADBEEF, 32'h3};
    vec[3] = '{32'h00000000, 32'h0,        32'h0,        5'd3,  32'hA5A5A5A5, 32'h20};
    vec[4] = '{32'h00600000, 32'hA5A5A5A5, 32'h0,        5'd4,  32'h44,       32'h1FF};
    vec[5] = '{32'h00830000, 32'h44,       32'hA5A5A5A5, 5'd31, 32'h31,       32'h5};

    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    spc = 32'd0;
    for (int i = 0; i < 6; i++) begin
      rom[spc[7:0]] = vec[i].ins;
      spc = vec[i].nextpc;
    end

    rst = 1'b1; run = 1'b0; wra = '0; result = '0; nextpc = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    spc = 32'd0;
    for (int i = 0; i < 6; i++) begin
      run_instr(vec[i], spc, i + 1);
      spc = vec[i].nextpc;
    end

    // r0 stays zero after the wra=0 write of 0xDEADBEEF
    dbg_addr = 5'd0;
    #1;
    check("r0_dbg", dbg_data, 32'd0);

    // stall: nothing moves with run low
    hold_pc = pc;
    hold_ic = icount;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_retire", {31'd0, retire}, 32'd0);
      check("stall_pc", pc, hold_pc);
      check("stall_icount", icount, hold_ic);
    end

    // reset landing in WB: write-back and pc update suppressed
    wra = 5'd3; result = 32'h999; nextpc = 32'h77; dbg_addr = 5'd3; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wbrst_retire_wb", {31'd0, retire}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wbrst_r3", dbg_data, 32'd0);
    check("wbrst_pc", pc, 32'd0);
    check("wbrst_icount", icount, 32'd0);
    check("wbrst_retire", {31'd0, retire}, 32'd0);

    // populate a register, then reset for 2 cycles in the middle of EXEC
    run_instr(vec[0], 32'd0, 1);
    wra = 5'd7; result = 32'h7; nextpc = 32'h9; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    check("execrst_ins_before", ins, vec[1].ins);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    // FSM must be back in FETCH and fully functional
    run_instr(vec[0], 32'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_writeback.md
Name: fetch_writeback

Overview:
- Front/back end for the single-issue RISC core: the other side of the execute interface.
- Drives the instruction word, PC and the two source-register values into execute.
- Accepts the destination address, result and next PC back from execute.
- Owns the PC, the 32x32 register file and the instruction-memory read port, sequenced by a 4-state multi-cycle FSM.

Parameters:
- IADDR_W, 8, width of the instruction-memory word address (imem_addr = pc[IADDR_W-1:0]).
- RESET_PC, 32'd0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- run  input  1  1 = allow a new fetch; sampled only in FETCH.
- imem_addr  output  IADDR_W  instruction-memory word address; synchronous ROM, data valid one cycle later.
- imem_rdata  input  32  instruction word from ROM.
- ins  output  32  registered instruction word to execute.
- pc  output  32  current PC to execute.
- reg1  output  32  rf[ins[25:21]] (rs).
- reg2  output  32  rf[ins[20:16]] (rt).
- wra  input  5  write-back register address from execute.
- result  input  32  write-back data from execute.
- nextpc  input  32  next PC from execute.
- retire  output  1  high for exactly the WB cycle of each instruction.
- icount  output  32  retired-instruction counter.
- dbg_addr  input  5  debug register-file read address.
- dbg_data  output  32  rf[dbg_addr], combinational; reads 0 for address 0.

Behaviour:
- Reset (rst=1 at a posedge), regardless of current state:
  - state=FETCH, pc=RESET_PC, ins=0, all 32 registers=0, icount=0.
  - No write-back and no PC update occur in that cycle, even if it lands in WB.
  - Consequence: reg1=reg2=0 and retire=0 after reset.
- FSM states, 2-bit encoding FETCH=0, DECODE=1, EXEC=2, WB=3; 4 cycles per instruction when run=1.
- FETCH:
  - imem_addr = pc[IADDR_W-1:0] combinationally, valid in every state.
  - run=1 -> DECODE; run=0 -> stay in FETCH (stall); pc, ins and rf unchanged while stalled.
- DECODE: ins <= imem_rdata; -> EXEC. The run input is ignored from here through WB.
- EXEC:
  - reg1/reg2 are combinational reads of rf through the held ins fields.
  - reg1/reg2 are valid from the first cycle of EXEC and stable through WB.
  - This cycle exists to absorb execute's synchronous data-memory read latency. -> WB.
- WB:
  - retire=1.
  - At the posedge, if wra != 0 then rf[wra] <= result; writes to r0 are discarded.
  - pc <= nextpc, full 32 bits, no masking; imem_addr takes the low IADDR_W bits, so wrap is natural.
  - icount <= icount+1, wrapping at 2^32.
  - -> FETCH.
- No forwarding is needed: write-back completes before the next DECODE, so a dependent next instruction sees the new value.
- r0 is hardwired to read as zero on reg1, reg2 and dbg_data.
- Lowering run mid-instruction never aborts it: the instruction retires, then the FSM holds in FETCH.
- ins and pc are held constant from DECODE exit through WB.
- Outputs to execute change only on state-transition edges.

Test Plan:
- Reset: assert rst 2 cycles in mid-EXEC with nonzero regs -> next cycle pc=0, imem_addr=0, ins=0, dbg_data=0 for all 32 addresses, retire=0, icount=0.
- Single retire: ROM[0]=0x04010005 (op1, rs0, rt1, imm 5), model returns wra=1, result=5, nextpc=1 -> ins=0x04010005 in EXEC, retire high exactly in cycle 4, dbg r1=5, pc=1, icount=1.
- Read-after-write: ROM[1]=0x00221800 (rs=1, rt=2) following the above -> reg1=5, reg2=0 in its EXEC cycle.
- r0 protection: model returns wra=0, result=0xDEADBEEF -> dbg r0=0, reg1 with rs=0 reads 0; retire still pulses.
- Stall: run=0 for 10 cycles in FETCH -> state, pc, icount frozen, no retire. run dropped during EXEC -> that instruction retires, then FETCH holds.
- Branch/wrap: nextpc=0x20 -> imem_addr=0x20 in next FETCH. nextpc=0x1FF with IADDR_W=8 -> pc=0x1FF, imem_addr=0xFF. rst asserted during WB with wra=3 -> r3 unchanged, pc=RESET_PC.
